// File: rtl/ingress_voq.sv
// Ingress virtual output queue buffer: files packet words into four per-egress
// queues and streams one granted, fully received packet at a time to the crossbar.
module ingress_voq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic [1:0]        enq_dest,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              enq_last,
    output logic              enq_ready,
    input  logic              sel_en,
    input  logic [1:0]        sel,
    output logic [3:0]        voq_empty,
    output logic              is_busy,
    output logic [1:0]        busy_voq_num,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, XMIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cur_voq_q, cur_voq_d;
    logic [PW-1:0]     wr_ptr_q [4];
    logic [PW-1:0]     wr_ptr_d [4];
    logic [PW-1:0]     rd_ptr_q [4];
    logic [PW-1:0]     rd_ptr_d [4];
    logic [PW-1:0]     pkt_cnt_q [4];
    logic [PW-1:0]     pkt_cnt_d [4];
    logic [3:0]        voq_empty_q;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0]  data_mem [4*DEPTH];
    logic [4*DEPTH-1:0] last_mem;

    logic [3:0]  full;
    logic        enq_fire, grant, xmit, rd_last;
    logic [AW+1:0] wr_addr, rd_addr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i] = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                      (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
        end
    end

    assign enq_ready = !full[enq_dest];
    assign enq_fire  = enq_valid && enq_ready;
    assign xmit      = (state_q == XMIT);
    // Eligibility uses the registered empty flags, so a just-completed packet waits one cycle.
    assign grant     = (state_q == IDLE) && sel_en && !voq_empty_q[sel];
    assign wr_addr   = {enq_dest, wr_ptr_q[enq_dest][AW-1:0]};
    assign rd_addr   = {cur_voq_q, rd_ptr_q[cur_voq_q][AW-1:0]};
    assign rd_last   = last_mem[rd_addr];

    always_comb begin
        state_d   = state_q;
        cur_voq_d = cur_voq_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = XMIT;
                    cur_voq_d = sel;
                end
            end
            XMIT: begin
                if (rd_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_ptr_d[i]  = wr_ptr_q[i];
            rd_ptr_d[i]  = rd_ptr_q[i];
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (enq_fire && enq_dest == 2'(i)) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
                if (enq_last) pkt_cnt_d[i] = pkt_cnt_d[i] + PW'(1);
            end
            if (grant && sel == 2'(i)) pkt_cnt_d[i] = pkt_cnt_d[i] - PW'(1);
            if (xmit && cur_voq_q == 2'(i)) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
        out_valid_d = xmit;
        out_last_d  = xmit && rd_last;
        out_data_d  = xmit ? data_mem[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_voq_q   <= 2'd0;
            voq_empty_q <= 4'hF;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_voq_q   <= cur_voq_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i]    <= wr_ptr_d[i];
                rd_ptr_q[i]    <= rd_ptr_d[i];
                pkt_cnt_q[i]   <= pkt_cnt_d[i];
                voq_empty_q[i] <= (pkt_cnt_q[i] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            data_mem[wr_addr] <= enq_data;
            last_mem[wr_addr] <= enq_last;
        end
    end

    assign voq_empty    = voq_empty_q;
    assign is_busy      = out_valid_q;
    assign busy_voq_num = cur_voq_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
endmodule
